// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module      : seq_restoring_divider
// Description : Iterative restoring divider, one quotient bit per clock.
//               Optional two's-complement mode when SIGNED_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_dvnd;
    logic             r_dbz;
    logic             r_ovf;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_ovf;
    logic [WIDTH-1:0] w_q_res;
    logic [WIDTH-1:0] w_r_res;

`ifdef SIGNED_DIV_EN
    assign w_a_neg = dividend[WIDTH-1];
    assign w_b_neg = divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor : divisor;
    assign w_ovf   = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
    assign w_a_mag = dividend;
    assign w_b_mag = divisor;
    assign w_ovf   = 1'b0;
`endif

    assign w_zero = (divisor == '0);
    assign w_last = (r_cnt == CNT_W'(1));

    // Partial remainder never exceeds the divisor, so the WIDTH+1-bit
    // difference is a valid signed value and its MSB is the restore decision.
    assign w_rem_sh = (r_rem << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};

    assign w_q_res = r_dbz ? {WIDTH{1'b1}} : (r_neg_q ? -r_q : r_q);
    assign w_r_res = r_dbz ? r_dvnd
                           : (r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_FIN: begin
                w_next = c_IDLE;
                if (start) begin
                    w_next = w_zero ? c_FIN : c_CALC;
                end
            end
            c_CALC: begin
                if (w_last) begin
                    w_next = c_FIN;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        ready    = (r_state == c_IDLE) || (r_state == c_FIN);
        w_accept = ready && start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_dvsr      <= '0;
            r_dvnd      <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rem   <= '0;
                r_q     <= w_a_mag;
                r_dvsr  <= w_b_mag;
                r_dvnd  <= dividend;
                r_cnt   <= CNT_W'(WIDTH);
                r_dbz   <= w_zero;
                r_ovf   <= w_ovf;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end else if (r_state == c_CALC) begin
                r_rem <= w_diff[WIDTH] ? w_rem_sh : w_diff;
                r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
                r_cnt <= r_cnt - CNT_W'(1);
            end

            done <= (r_state == c_FIN);

            // A start taken in FIN must not clobber the result being published.
            if (r_state == c_FIN) begin
                quotient    <= w_q_res;
                remainder   <= w_r_res;
                div_by_zero <= r_dbz;
                overflow    <= r_ovf;
            end else if (w_accept) begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Directed self-checking bench for seq_restoring_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_chk;
    int n_fail;

    seq_restoring_divider #(.WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present a request and consume the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; capped at 200.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 200);
    endtask

    task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic dbz, input logic ovf);
        check_eq({tag, "_q"}, 64'(quotient), 64'(q));
        check_eq({tag, "_r"}, 64'(remainder), 64'(r));
        check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(dbz));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(ovf));
    endtask

    initial begin
        int lat;
        logic saw_done;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_done", 64'(done), 64'd0);
        check_res("rst", 32'd0, 32'd0, 1'b0, 1'b0);

        launch(32'd100, 32'd7);
        check_eq("busy_ready", 64'(ready), 64'd0);
        wait_done(lat);
        check_eq("lat_100_7", 64'(lat), 64'd33);
        check_res("d100_7", 32'd14, 32'd2, 1'b0, 1'b0);
        check_eq("done_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq("done_pulse", 64'(done), 64'd0);
        check_eq("idle_ready", 64'(ready), 64'd1);

        // Back-to-back: second start issued in the done cycle.
        launch(32'hFFFF_FFFF, 32'd1);
        wait_done(lat);
        check_res("dmax_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        launch(32'd5, 32'd9);
        wait_done(lat);
        check_eq("lat_5_9", 64'(lat), 64'd33);
        check_res("d5_9", 32'd0, 32'd5, 1'b0, 1'b0);

        launch(32'd1234, 32'd0);
        wait_done(lat);
        check_eq("lat_dbz", 64'(lat), 64'd1);
        check_res("dbz", 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        launch(32'd20, 32'd6);
        check_eq("dbz_clear_on_start", 64'(div_by_zero), 64'd0);
        wait_done(lat);
        check_res("d20_6", 32'd3, 32'd2, 1'b0, 1'b0);

        launch(32'd0, 32'd5);
        wait_done(lat);
        check_eq("lat_zero", 64'(lat), 64'd33);
        check_res("d0_5", 32'd0, 32'd0, 1'b0, 1'b0);

        // A start while busy must be ignored.
        launch(32'd1000, 32'd3);
        lat = 0;
        saw_done = 1'b0;
        while (!saw_done && lat < 200) begin
            if (lat == 9) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            saw_done = done;
        end
        start = 1'b0;
        check_eq("lat_ignore", 64'(lat), 64'd33);
        check_res("d1000_3", 32'd333, 32'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("ignore_no_second_done", 64'(done), 64'd0);
        check_eq("ignore_ready", 64'(ready), 64'd1);

        // Abort: reset mid-calculation suppresses done and clears outputs.
        launch(32'd1000, 32'd3);
        saw_done = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            start = (c == 10);
            if (c == 10) begin
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            rst = (c == 20);
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        rst   = 1'b0;
        start = 1'b0;
        check_eq("abort_ready", 64'(ready), 64'd1);
        check_res("abort", 32'd0, 32'd0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 64'(saw_done), 64'd0);

`ifdef SIGNED_DIV_EN
        launch(32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check_eq("lat_signed", 64'(lat), 64'd33);
        check_res("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        launch(32'd7, 32'hFFFF_FFFE);
        wait_done(lat);
        check_res("s7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check_res("smin_m1", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        launch(32'hFFFF_FFF9, 32'd0);
        wait_done(lat);
        check_res("s_dbz", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
`else
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check_res("umin_m1", 32'd0, 32'h8000_0000, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
